nib_sub_seq: RTL and testbench
==============================

NIB_SUB_SEQ -- requirements
Module: nib_sub_seq

Interface
REQ-001 Parameter: NIBBLES, 4, number of 4-bit slices per operand; the operand width W = 4*NIBBLES, and NIBBLES SHALL be >= 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request to begin one subtraction.
REQ-005 Port: a  input  W  minuend.
REQ-006 Port: b  input  W  subtrahend.
REQ-007 Port: bin  input  1  borrow-in to the least significant nibble.
REQ-008 Port: busy  output  1  high while a subtraction is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when the result is valid.
REQ-010 Port: d  output  W  difference, registered.
REQ-011 Port: bout  output  1  borrow-out of the most significant nibble, registered.
REQ-012 Port: ov  output  1  signed-overflow flag for the completed result, registered.

Function
REQ-013 The block SHALL compute a - b - bin serially, one 4-bit nibble per clock, LSB nibble first, using a single internal 4-bit subtract datapath (nibble diff plus borrow-out).
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE with start=1 at an edge: latch a, b and bin into internal registers, clear the nibble index to 0, go to RUN.
REQ-016 RUN, each edge: process nibble k = index, diff_k = a_k - b_k - borrow_reg (mod 16), borrow_reg <= borrow of that step, write diff_k into the result-shadow register, index <= index + 1.
REQ-017 The borrow_reg value used for nibble 0 SHALL be the latched bin.
REQ-018 RUN after nibble NIBBLES-1 is processed: go to DONE and load d, bout and ov from the shadow result and final borrow on that same edge.
REQ-019 Latency: if start is sampled at edge T, done SHALL be high in the cycle following edge T+NIBBLES, and low otherwise.
REQ-020 DONE SHALL last exactly one cycle: with start=1, latch new operands and go to RUN (back-to-back); otherwise go to IDLE.
REQ-021 busy SHALL equal 1 exactly while the state is RUN.
REQ-022 start asserted while in RUN SHALL be ignored; it is neither queued nor does it affect the operation in progress.
REQ-023 Changes on a, b or bin after the start edge SHALL NOT affect the result in progress.
REQ-024 d, bout and ov SHALL hold their last values from completion until the next completion; partial nibbles SHALL NOT be visible on d.
REQ-025 ov SHALL be defined as (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]), evaluated on the latched operands and the final difference.
REQ-026 bout=1 SHALL indicate that a < b + bin when a and b are read as unsigned values.
REQ-027 The nibble index SHALL be ceil(log2(NIBBLES))+1 bits wide and SHALL never wrap during RUN.

Reset
REQ-028 While rst_n=0 the block SHALL immediately force: state=IDLE, busy=0, done=0, d=0, bout=0, ov=0, and all internal operand, borrow, index and shadow registers to 0.
REQ-029 Reset asserted mid-RUN SHALL abandon the operation, with no done pulse afterward.
REQ-030 The first edge after rst_n deasserts SHALL accept start.

Verification (NIBBLES=4)
REQ-031 Case 1: a=0x1234, b=0x0234, bin=0, start pulse. Required: busy high 4 cycles, done 4 cycles after start, d=0x1000, bout=0, ov=0.
REQ-032 Case 2: a=0x0000, b=0x0001, bin=0. Required: d=0xFFFF, bout=1, ov=0. Same operands with bin=1: d=0xFFFE, bout=1.
REQ-033 Case 3: a=0x8000, b=0x0001, bin=0. Required: d=0x7FFF, bout=0, ov=1.
REQ-034 Case 4: start with a=0x00F0, b=0x000F, then change a/b and pulse start again during RUN. Required: a single done, d=0x00E1, no second operation.
REQ-035 Case 5: assert rst_n=0 in the 2nd RUN cycle. Required: busy, done, d, bout and ov are 0 immediately; no done pulse; the next start runs normally.
REQ-036 Case 6: hold start=1 across the DONE cycle, with operands 0x0005-0x0003 and then 0xFFFF-0xFFFF. Required: done pulses 5 cycles apart, with d=0x0002 and then d=0x0000, both bout=0.

Source files
------------

// File: rtl/nib_sub_seq.sv
// Serial subtractor: computes a - b - bin one nibble per clock, LSB first,
// through a single 4-bit subtract slice, then publishes d/bout/ov at once.
module nib_sub_seq #(
  parameter  int unsigned NIBBLES = 4,
  localparam int unsigned W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         bout,
  output logic         ov
);

  localparam int unsigned IDXW = $clog2(NIBBLES) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            borrow_reg;
  logic [IDXW-1:0] idx;
  logic [W-1:0]    shadow;

  logic [3:0]      a_nib_c;
  logic [3:0]      b_nib_c;
  logic [4:0]      diff_c;
  logic [W-1:0]    shadow_c;
  logic            last_c;
  logic            ov_c;
  logic            accept_c;

  // Nibble select, 4-bit subtract slice and shadow merge.
  always_comb begin
    a_nib_c  = '0;
    b_nib_c  = '0;
    shadow_c = shadow;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (idx == IDXW'(i)) begin
        a_nib_c = a_reg[4*i +: 4];
        b_nib_c = b_reg[4*i +: 4];
      end
    end
    diff_c = {1'b0, a_nib_c} - {1'b0, b_nib_c} - 5'(borrow_reg);
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (idx == IDXW'(i)) begin
        shadow_c[4*i +: 4] = diff_c[3:0];
      end
    end
    last_c = (idx == IDXW'(NIBBLES - 1));
    ov_c   = (a_reg[W-1] != b_reg[W-1]) && (shadow_c[W-1] != a_reg[W-1]);
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
          accept_c   = 1'b1;
        end
      end
      RUN: begin
        if (last_c) next_state = DONE;
      end
      DONE: begin
        if (start) begin
          next_state = RUN;
          accept_c   = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == RUN);
      done  <= (next_state == DONE);
    end
  end

  // Operand capture, per-nibble progress and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      idx        <= '0;
      shadow     <= '0;
      d          <= '0;
      bout       <= 1'b0;
      ov         <= 1'b0;
    end else if (accept_c) begin
      a_reg      <= a;
      b_reg      <= b;
      borrow_reg <= bin;
      idx        <= '0;
      shadow     <= '0;
    end else if (state == RUN) begin
      borrow_reg <= diff_c[4];
      shadow     <= shadow_c;
      idx        <= idx + IDXW'(1);
      if (last_c) begin
        d    <= shadow_c;
        bout <= diff_c[4];
        ov   <= ov_c;
      end
    end
  end

endmodule

// File: tb/tb_nib_sub_seq.sv
// Directed self-checking bench for nib_sub_seq with NIBBLES=4.
module tb_nib_sub_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] d;
  logic        bout;
  logic        ov;

  int checks;
  int errors;
  int cyc;

  nib_sub_seq #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .ov    (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse start for one edge, then wait (bounded) for done; done is high on return.
  task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                       output int lat, output int bcnt);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (busy) bcnt++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL op_timeout a=%h b=%h: no done within 20 cycles", ia, ib);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, d, bout, ov} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b d=%h bout=%b ov=%b want all 0",
               busy, done, d, bout, ov);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bcnt;
    do_op(16'h1234, 16'h0234, 1'b0, lat, bcnt);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d want 4", lat); end
    checks++;
    if (bcnt !== 4) begin errors++; $display("FAIL basic_busy_cycles got %0d want 4", bcnt); end
    checks++;
    if ({d, bout, ov} !== {16'h1000, 1'b0, 1'b0}) begin
      errors++; $display("FAIL basic_result got d=%h bout=%b ov=%b want 1000 0 0", d, bout, ov);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy} !== 2'b00 || d !== 16'h1000) begin
      errors++; $display("FAIL basic_after got done=%b busy=%b d=%h want 0 0 1000", done, busy, d);
    end
  endtask

  task automatic test_borrow();
    int lat, bcnt;
    do_op(16'h0000, 16'h0001, 1'b0, lat, bcnt);
    checks++;
    if ({d, bout, ov} !== {16'hFFFF, 1'b1, 1'b0}) begin
      errors++; $display("FAIL borrow_bin0 got d=%h bout=%b ov=%b want ffff 1 0", d, bout, ov);
    end
    @(posedge clk); #1;
    do_op(16'h0000, 16'h0001, 1'b1, lat, bcnt);
    checks++;
    if ({d, bout} !== {16'hFFFE, 1'b1}) begin
      errors++; $display("FAIL borrow_bin1 got d=%h bout=%b want fffe 1", d, bout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int lat, bcnt;
    do_op(16'h8000, 16'h0001, 1'b0, lat, bcnt);
    checks++;
    if ({d, bout, ov} !== {16'h7FFF, 1'b0, 1'b1}) begin
      errors++; $display("FAIL ovf_neg got d=%h bout=%b ov=%b want 7fff 0 1", d, bout, ov);
    end
    @(posedge clk); #1;
    do_op(16'h7FFF, 16'hFFFF, 1'b0, lat, bcnt);
    checks++;
    if ({d, bout, ov} !== {16'h8000, 1'b1, 1'b1}) begin
      errors++; $display("FAIL ovf_pos got d=%h bout=%b ov=%b want 8000 1 1", d, bout, ov);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int ndone;
    logic [15:0] dseen;
    a = 16'h00F0; b = 16'h000F; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'h1111; b = 16'h2222; bin = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (d !== 16'h8000 || busy !== 1'b1) begin
      errors++; $display("FAIL ign_hold_mid_run got d=%h busy=%b want 8000 1", d, busy);
    end
    ndone = 0; dseen = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; dseen = d; end
    end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", ndone); end
    checks++;
    if (dseen !== 16'h00E1 || d !== 16'h00E1 || busy !== 1'b0) begin
      errors++; $display("FAIL ign_result got d=%h final=%h busy=%b want 00e1 00e1 0", dseen, d, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone, lat, bcnt;
    a = 16'h0F0F; b = 16'h0101; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, d, bout, ov} !== 20'h0) begin
      errors++;
      $display("FAIL rst_mid_run got busy=%b done=%b d=%h bout=%b ov=%b want all 0",
               busy, done, d, bout, ov);
    end
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL rst_no_done got %0d active cycles want 0", ndone); end
    @(negedge clk);
    do_op(16'h0010, 16'h0001, 1'b0, lat, bcnt);
    checks++;
    if (lat !== 4 || {d, bout, ov} !== {16'h000F, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_next_op got lat=%0d d=%h bout=%b ov=%b want 4 000f 0 0",
                         lat, d, bout, ov);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    a = 16'h0005; b = 16'h0003; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    t1 = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) begin t1 = cyc; break; end
    end
    checks++;
    if (t1 < 0 || {d, bout} !== {16'h0002, 1'b0}) begin
      errors++; $display("FAIL b2b_first got t=%0d d=%h bout=%b want 0002 0", t1, d, bout);
    end
    a = 16'hFFFF; b = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++; $display("FAIL b2b_restart got busy=%b done=%b want 1 0", busy, done);
    end
    t2 = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) begin t2 = cyc; break; end
    end
    checks++;
    if (t2 - t1 !== 5 || {d, bout, ov} !== {16'h0000, 1'b0, 1'b0}) begin
      errors++; $display("FAIL b2b_second got gap=%0d d=%h bout=%b ov=%b want 5 0000 0 0",
                         t2 - t1, d, bout, ov);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
